// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 panel driver.
package hub75_pkg;

   localparam int DEF_NUM_ROWS  = 64;
   localparam int DEF_SCAN_RATE = 32;
   localparam int DEF_RGB_RES   = 9;
   localparam int DEF_BASE_ON   = 8;

   typedef enum logic [2:0] {
      ST_REQ,
      ST_WAIT,
      ST_SHIFT,
      ST_LATCH,
      ST_DISPLAY
   } state_e;

   // Number of BCM bit planes: one per bit of each colour channel.
   function automatic int planes_of(input int rgb_res);
      return rgb_res / 3;
   endfunction

   // Index width that never collapses to zero bits.
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // {r,g,b} bit of one pixel for a given plane; pixel packed {R,G,B}.
   function automatic logic [2:0] pixel_bits(input logic [31:0] pix,
                                             input int unsigned planes,
                                             input int unsigned plane);
      logic [4:0] r_idx;
      logic [4:0] g_idx;
      logic [4:0] b_idx;
      r_idx = 5'(2 * planes + plane);
      g_idx = 5'(planes + plane);
      b_idx = 5'(plane);
      return {pix[r_idx], pix[g_idx], pix[b_idx]};
   endfunction

endpackage

// File: rtl/hub75_if.sv
// Column-streaming handshake between the frame manager and the panel driver.
interface hub75_if #(
   parameter int NUM_ROWS  = 64,
   parameter int SCAN_RATE = 32,
   parameter int RGB_RES   = 9
);
   localparam int ADDR_W = $clog2(SCAN_RATE);

   logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] columns;
   logic [ADDR_W-1:0]                     col_num1;
   logic                                  data_valid;
   logic                                  hub75_ready;

   modport master (output columns, output col_num1, output data_valid, input  hub75_ready);
   modport slave  (input  columns, input  col_num1, input  data_valid, output hub75_ready);
endinterface

// File: rtl/hub75_bitplane.sv
// Selects the six panel data bits for one pixel of a line pair in one plane.
module hub75_bitplane
   import hub75_pkg::*;
#(
   parameter int NUM_ROWS = 64,
   parameter int RGB_RES  = 9,
   parameter int PIX_W    = width_of(NUM_ROWS),
   parameter int PLANE_W  = width_of(planes_of(RGB_RES))
) (
   input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] columns,
   input  logic [PIX_W-1:0]                      pix,
   input  logic [PLANE_W-1:0]                    plane,
   output logic [5:0]                            bits   // {r0,g0,b0,r1,g1,b1}
);
   localparam int P = planes_of(RGB_RES);

   // Half 0 feeds the upper three bits, half 1 the lower three.
   for (genvar h = 0; h < 2; h++) begin : g_half
      assign bits[5-3*h -: 3] = pixel_bits(32'(columns[h][pix]), unsigned'(P), 32'(plane));
   end

endmodule

// File: rtl/hub75_driver.sv
// HUB75 panel driver: requests a line pair, then shifts/latches/displays it
// once per BCM bit plane with display time doubling per plane.
module hub75_driver
   import hub75_pkg::*;
#(
   parameter int NUM_ROWS  = DEF_NUM_ROWS,
   parameter int SCAN_RATE = DEF_SCAN_RATE,
   parameter int RGB_RES   = DEF_RGB_RES,
   parameter int BASE_ON   = DEF_BASE_ON
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   hub75_if.slave                       bus,
   output logic                         r0,
   output logic                         g0,
   output logic                         b0,
   output logic                         r1,
   output logic                         g1,
   output logic                         b1,
   output logic                         hub_clk,
   output logic                         hub_lat,
   output logic                         hub_oe,
   output logic [$clog2(SCAN_RATE)-1:0] hub_addr
);
   localparam int P       = planes_of(RGB_RES);
   localparam int ADDR_W  = $clog2(SCAN_RATE);
   localparam int PIX_W   = width_of(NUM_ROWS);
   localparam int PLANE_W = width_of(P);
   localparam int CNT_W   = width_of((BASE_ON << (P - 1)) + 1);

   localparam logic [PIX_W-1:0]   LAST_PIX   = PIX_W'(NUM_ROWS - 1);
   localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(P - 1);

   typedef logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] line_pair_t;

   state_e             state_q, state_d;
   logic               ready_q, ready_d;
   logic [5:0]         data_q, data_d;
   logic               clk_q, clk_d;
   logic               lat_q, lat_d;
   logic               oe_q, oe_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   line_pair_t         cols_q, cols_d;
   logic [ADDR_W-1:0]  cap_addr_q, cap_addr_d;
   logic [PLANE_W-1:0] plane_q, plane_d;
   logic [PIX_W-1:0]   pix_q, pix_d;
   logic               phase_q, phase_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // Outputs are registered from next-state values, so the bit selector is
   // pointed at whichever pixel/plane is about to be driven: the incoming bus
   // on capture, otherwise the captured copy.
   line_pair_t         bp_cols;
   logic [PIX_W-1:0]   bp_pix;
   logic [PLANE_W-1:0] bp_plane;
   logic [5:0]         bp_bits;

   assign bp_cols  = (state_q == ST_WAIT) ? bus.columns : cols_q;
   assign bp_pix   = (state_q == ST_SHIFT) ? pix_q + PIX_W'(1) : '0;
   assign bp_plane = (state_q == ST_DISPLAY) ? plane_q + PLANE_W'(1) :
                     (state_q == ST_SHIFT)   ? plane_q : '0;

   hub75_bitplane #(
      .NUM_ROWS (NUM_ROWS),
      .RGB_RES  (RGB_RES),
      .PIX_W    (PIX_W),
      .PLANE_W  (PLANE_W)
   ) u_bitplane (
      .columns (bp_cols),
      .pix     (bp_pix),
      .plane   (bp_plane),
      .bits    (bp_bits)
   );

   // Next-state and next-output logic for the request/shift/latch/display loop.
   always_comb begin
      state_d    = state_q;
      ready_d    = 1'b0;
      data_d     = data_q;
      clk_d      = clk_q;
      lat_d      = 1'b0;
      oe_d       = oe_q;
      addr_d     = addr_q;
      cols_d     = cols_q;
      cap_addr_d = cap_addr_q;
      plane_d    = plane_q;
      pix_d      = pix_q;
      phase_d    = phase_q;
      cnt_d      = cnt_q;
      case (state_q)
         ST_REQ: begin
            // Coming out of reset REQ is entered with ready low; raise it once.
            ready_d = 1'b1;
            if (ready_q) begin
               ready_d = 1'b0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.data_valid) begin
               cols_d     = bus.columns;
               cap_addr_d = bus.col_num1;
               plane_d    = '0;
               pix_d      = '0;
               phase_d    = 1'b0;
               data_d     = bp_bits;
               clk_d      = 1'b0;
               state_d    = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (!phase_q) begin
               phase_d = 1'b1;
               clk_d   = 1'b1;
            end else if (pix_q == LAST_PIX) begin
               clk_d   = 1'b0;
               lat_d   = 1'b1;
               oe_d    = 1'b1;
               addr_d  = cap_addr_q;
               state_d = ST_LATCH;
            end else begin
               pix_d   = pix_q + PIX_W'(1);
               phase_d = 1'b0;
               clk_d   = 1'b0;
               data_d  = bp_bits;
            end
         end
         ST_LATCH: begin
            oe_d    = 1'b0;
            cnt_d   = (CNT_W'(BASE_ON) << plane_q) - CNT_W'(1);
            state_d = ST_DISPLAY;
         end
         ST_DISPLAY: begin
            if (cnt_q == '0) begin
               oe_d = 1'b1;
               if (plane_q != LAST_PLANE) begin
                  plane_d = plane_q + PLANE_W'(1);
                  pix_d   = '0;
                  phase_d = 1'b0;
                  data_d  = bp_bits;
                  state_d = ST_SHIFT;
               end else begin
                  ready_d = 1'b1;
                  state_d = ST_REQ;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_REQ;
      endcase
   end

   // State and output registers; reset abandons any pair in flight.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= ST_REQ;
         ready_q    <= 1'b0;
         data_q     <= '0;
         clk_q      <= 1'b0;
         lat_q      <= 1'b0;
         oe_q       <= 1'b1;
         addr_q     <= '0;
         cols_q     <= '0;
         cap_addr_q <= '0;
         plane_q    <= '0;
         pix_q      <= '0;
         phase_q    <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         data_q     <= data_d;
         clk_q      <= clk_d;
         lat_q      <= lat_d;
         oe_q       <= oe_d;
         addr_q     <= addr_d;
         cols_q     <= cols_d;
         cap_addr_q <= cap_addr_d;
         plane_q    <= plane_d;
         pix_q      <= pix_d;
         phase_q    <= phase_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.hub75_ready          = ready_q;
   assign {r0, g0, b0, r1, g1, b1} = data_q;
   assign hub_clk                  = clk_q;
   assign hub_lat                  = lat_q;
   assign hub_oe                   = oe_q;
   assign hub_addr                 = addr_q;

endmodule

// File: tb/tb_hub75_driver.sv
// Directed bench for hub75_driver with default parameters.
module tb_hub75_driver;

   typedef logic [1:0][63:0][8:0] cols_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       r0, g0, b0, r1, g1, b1;
   logic       hub_clk, hub_lat, hub_oe;
   logic [4:0] hub_addr;
   logic [5:0] data;
   int         cyc = 0;
   int         checks = 0;
   int         errs = 0;

   // per-pair observations filled by monitor_pair
   int         rises [3];
   int         oe_low [3];
   logic [5:0] first_px [3];
   logic [5:0] d_and, d_or;
   logic [4:0] lat_addr;
   int         ready_delay;
   bit         addr_glitch;

   hub75_if #(.NUM_ROWS(64), .SCAN_RATE(32), .RGB_RES(9)) bus ();

   hub75_driver #(.NUM_ROWS(64), .SCAN_RATE(32), .RGB_RES(9), .BASE_ON(8)) dut (
      .clk_in (clk), .rst_in (rst), .bus (bus),
      .r0 (r0), .g0 (g0), .b0 (b0), .r1 (r1), .g1 (g1), .b1 (b1),
      .hub_clk (hub_clk), .hub_lat (hub_lat), .hub_oe (hub_oe), .hub_addr (hub_addr)
   );

   assign data = {r0, g0, b0, r1, g1, b1};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic reset_dut();
      rst = 1'b1;
      bus.data_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Waits for ready, then returns data_valid in the following cycle.
   task automatic serve(input cols_t c, input logic [4:0] a, input bit keep, output int cap_cyc);
      bit found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (bus.hub75_ready === 1'b1) found = 1;
      end
      checks++;
      if (!found) begin
         errs++;
         $display("FAIL serve_ready: hub75_ready never seen, required 1 within 20 cycles");
      end
      @(negedge clk);
      bus.columns    = c;
      bus.col_num1   = a;
      bus.data_valid = 1'b1;
      @(negedge clk);
      cap_cyc = cyc;
      if (!keep) bus.data_valid = 1'b0;
   endtask

   // Observes one pair from the first SHIFT cycle until ready returns.
   task automatic monitor_pair(input int cap_cyc);
      int         lat_n = 0;
      bit         prev_clk = 0;
      bit         done = 0;
      logic [4:0] prev_addr;
      prev_addr   = hub_addr;
      d_and       = 6'h3F;
      d_or        = 6'h00;
      lat_addr    = 5'h1F;
      addr_glitch = 0;
      ready_delay = -1;
      for (int p = 0; p < 3; p++) begin
         rises[p] = 0; oe_low[p] = 0; first_px[p] = 6'h00;
      end
      for (int i = 0; i < 2000 && !done; i++) begin
         if (bus.hub75_ready === 1'b1) begin
            ready_delay = cyc - cap_cyc;
            done = 1;
         end else begin
            if (hub_clk && !prev_clk && lat_n < 3) begin
               if (rises[lat_n] == 0) first_px[lat_n] = data;
               rises[lat_n]++;
            end
            if (hub_oe && !hub_lat) begin
               d_and &= data;
               d_or  |= data;
            end
            if (hub_lat) begin
               if (lat_n == 0) lat_addr = hub_addr;
               lat_n++;
            end
            if (!hub_oe && lat_n >= 1 && lat_n <= 3) oe_low[lat_n-1]++;
            if (hub_addr !== prev_addr && !(hub_lat && hub_oe)) addr_glitch = 1;
            prev_clk  = hub_clk;
            prev_addr = hub_addr;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.data_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.hub75_ready, data, hub_clk, hub_lat, hub_oe, hub_addr} !== {1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 5'd0}) begin
         errs++;
         $display("FAIL reset_outputs: got rdy=%b data=%h clk=%b lat=%b oe=%b addr=%0d, required 0 00 0 0 1 0",
                  bus.hub75_ready, data, hub_clk, hub_lat, hub_oe, hub_addr);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.hub75_ready !== 1'b1 || hub_oe !== 1'b1 || hub_addr !== 5'd0) begin
         errs++;
         $display("FAIL reset_first_ready: got rdy=%b oe=%b addr=%0d, required 1 1 0", bus.hub75_ready, hub_oe, hub_addr);
      end
      @(negedge clk);
      checks++;
      if (bus.hub75_ready !== 1'b0) begin
         errs++;
         $display("FAIL reset_ready_single: got %b, required 0", bus.hub75_ready);
      end
   endtask

   task automatic test_full_white();
      cols_t c;
      int    cc;
      for (int h = 0; h < 2; h++) for (int k = 0; k < 64; k++) c[h][k] = 9'h1FF;
      reset_dut();
      serve(c, 5'd5, 0, cc);
      monitor_pair(cc);
      for (int p = 0; p < 3; p++) begin
         checks++;
         if (rises[p] != 64) begin
            errs++;
            $display("FAIL white_rises plane %0d: got %0d, required 64", p, rises[p]);
         end
         checks++;
         if (oe_low[p] != (8 << p)) begin
            errs++;
            $display("FAIL white_oe_low plane %0d: got %0d, required %0d", p, oe_low[p], 8 << p);
         end
      end
      checks++;
      if (d_and !== 6'h3F) begin
         errs++;
         $display("FAIL white_data: AND of shifted data %h, required 3f", d_and);
      end
      checks++;
      if (lat_addr !== 5'd5) begin
         errs++;
         $display("FAIL white_latch_addr: got %0d, required 5", lat_addr);
      end
      checks++;
      if (ready_delay != 443) begin
         errs++;
         $display("FAIL white_ready_delay: got %0d, required 443", ready_delay);
      end
      checks++;
      if (addr_glitch) begin
         errs++;
         $display("FAIL white_addr_change: hub_addr moved outside LATCH, required stable");
      end
   endtask

   task automatic test_plane_bits();
      cols_t            c;
      int               cc;
      logic [5:0] exp_px [3];
      exp_px[0] = 6'b101_000; exp_px[1] = 6'b010_000; exp_px[2] = 6'b100_000;
      c = '0;
      c[0][0] = 9'b101_010_001;
      reset_dut();
      serve(c, 5'd26, 0, cc);
      monitor_pair(cc);
      for (int p = 0; p < 3; p++) begin
         checks++;
         if (first_px[p] !== exp_px[p]) begin
            errs++;
            $display("FAIL plane_pixel0 plane %0d: got %b, required %b", p, first_px[p], exp_px[p]);
         end
      end
      checks++;
      if (d_or[2:0] !== 3'b000) begin
         errs++;
         $display("FAIL plane_lower_zero: got %b, required 000", d_or[2:0]);
      end
      checks++;
      if (lat_addr !== 5'd26) begin
         errs++;
         $display("FAIL plane_latch_addr: got %0d, required 26", lat_addr);
      end
   endtask

   task automatic test_req_valid_ignored();
      cols_t c;
      bit    active = 0;
      bit    found = 0;
      for (int h = 0; h < 2; h++) for (int k = 0; k < 64; k++) c[h][k] = 9'h1FF;
      reset_dut();
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (bus.hub75_ready === 1'b1) found = 1;
      end
      bus.columns = c;
      bus.col_num1 = 5'd7;
      bus.data_valid = 1'b1;
      @(negedge clk);
      bus.data_valid = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (hub_clk || hub_lat || !hub_oe || bus.hub75_ready) active = 1;
      end
      checks++;
      if (!found || active) begin
         errs++;
         $display("FAIL req_valid_ignored: ready_seen=%b activity=%b, required 1 0", found, active);
      end
   endtask

   task automatic test_hold_valid();
      cols_t c;
      int    cc;
      c = '0;
      for (int k = 0; k < 64; k++) c[1][k] = 9'h1FF;
      reset_dut();
      serve(c, 5'd3, 1, cc);
      fork
         monitor_pair(cc);
         begin
            for (int i = 0; i < 300; i++) begin
               @(negedge clk);
               for (int h = 0; h < 2; h++) for (int k = 0; k < 64; k++) bus.columns[h][k] = 9'($urandom);
               bus.col_num1 = 5'($urandom);
            end
            bus.data_valid = 1'b0;
         end
      join
      checks++;
      if (d_and[2:0] !== 3'b111 || d_or[5:3] !== 3'b000) begin
         errs++;
         $display("FAIL hold_data: AND=%b OR=%b, required lower 111 upper 000", d_and, d_or);
      end
      checks++;
      if (lat_addr !== 5'd3) begin
         errs++;
         $display("FAIL hold_latch_addr: got %0d, required 3", lat_addr);
      end
      checks++;
      if (ready_delay != 443) begin
         errs++;
         $display("FAIL hold_ready_delay: got %0d, required 443", ready_delay);
      end
   endtask

   task automatic test_reset_mid();
      cols_t c;
      int    cc;
      int    lat_n = 0;
      int    dcnt = 0;
      bit    bad = 0;
      for (int h = 0; h < 2; h++) for (int k = 0; k < 64; k++) c[h][k] = 9'h0AA;
      reset_dut();
      serve(c, 5'd9, 0, cc);
      for (int i = 0; i < 1000 && dcnt < 5; i++) begin
         @(negedge clk);
         if (hub_lat) lat_n++;
         if (lat_n == 2 && !hub_oe) dcnt++;
      end
      checks++;
      if (dcnt < 5) begin
         errs++;
         $display("FAIL mid_reach_plane1: display cycles seen %0d, required 5", dcnt);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.hub75_ready, data, hub_clk, hub_lat, hub_oe, hub_addr} !== {1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 5'd0}) begin
         errs++;
         $display("FAIL mid_reset_outputs: got rdy=%b data=%h clk=%b lat=%b oe=%b addr=%0d, required 0 00 0 0 1 0",
                  bus.hub75_ready, data, hub_clk, hub_lat, hub_oe, hub_addr);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.hub75_ready !== 1'b1) begin
         errs++;
         $display("FAIL mid_ready_after_release: got %b, required 1", bus.hub75_ready);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.hub75_ready || hub_lat || !hub_oe) bad = 1;
      end
      checks++;
      if (bad) begin
         errs++;
         $display("FAIL mid_no_partial: ready/latch/display activity after abandon, required none");
      end
   endtask

   initial begin
      bus.columns    = '0;
      bus.col_num1   = '0;
      bus.data_valid = 1'b0;
      test_reset();
      test_full_white();
      test_plane_bits();
      test_req_valid_ignored();
      test_hold_valid();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end

endmodule
